convert_outputs_div: RTL and testbench

Output-side counterpart of the divider/sqrt input conversion. It takes the divider's double-format result and returns it in the destination precision. For P=1 (single), it re-biases the exponent, rounds the 52-bit fraction to 23 bits per Rm, saturates or flushes out-of-range values, and NaN-boxes the result. It is a 2-stage valid/ready pipeline between the divider core and FPU writeback.

---
 rtl/fpu_div_pkg.sv | 46 ++++
 rtl/div_round_single.sv | 25 ++
 rtl/convert_outputs_div.sv | 168 ++++++++++++++++
 tb/tb_convert_outputs_div.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared constants and types for the divider/sqrt output conversion path.
// Holds rounding-mode codes, bias values, NaN-boxing constants and the stage-1 decode record.
package fpu_div_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RZ  = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int DBL_BIAS   = 1023;
    localparam int SGL_BIAS   = 127;
    localparam int BIAS_DELTA = DBL_BIAS - SGL_BIAS;

    localparam logic [31:0] SGL_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] NAN_BOX  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_OVF,
        CLS_UNF
    } cls_e;

    typedef struct packed {
        logic        p;
        logic [63:0] res;
        logic        sign;
        cls_e        cls;
        logic [7:0]  exp;
        logic [22:0] man;
        logic        nx;
        logic        sticky;
        logic        rnd;
        logic [2:0]  rm;
    } s1_t;

    // Overflow saturates to infinity only when rounding moves away from zero.
    function automatic logic ovf_to_inf(input logic sign, input logic [2:0] rm);
        return (rm == RM_RNE) || (rm == RM_RMM) ||
               ((rm == RM_RUP) && !sign) || ((rm == RM_RDN) && sign);
    endfunction

endpackage

// File: rtl/div_round_single.sv
// Round-up decision for a double-to-single fraction truncation.
// Purely combinational; reserved rounding codes behave as round-to-nearest-even.
module div_round_single
    import fpu_div_pkg::*;
(
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    input  logic [2:0] rm_i,
    output logic       rnd_o
);

    always_comb begin
        rnd_o = 1'b0;
        case (rm_i)
            RM_RZ:   rnd_o = 1'b0;
            RM_RDN:  rnd_o = sign_i & (guard_i | sticky_i);
            RM_RUP:  rnd_o = ~sign_i & (guard_i | sticky_i);
            RM_RMM:  rnd_o = guard_i;
            default: rnd_o = guard_i & (sticky_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/convert_outputs_div.sv
// Converts the divider's double result to the destination precision (single is NaN-boxed).
// Two registered stages (decode, pack) with valid/ready; shifts without bubbles under full flow.
module convert_outputs_div
    import fpu_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [63:0] Res,
    input  logic        Sticky,
    input  logic        P,
    input  logic [2:0]  Rm,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [63:0] Result,
    output logic [2:0]  Flags
);

    logic        s1v_q, s1v_d;
    s1_t         s1_q, s1_d;
    logic        s2v_q, s2v_d;
    logic [63:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;

    logic        advance1;
    logic        accept;

    assign advance1 = ~s2v_q | OutReady;
    assign InReady  = ~s1v_q | advance1;
    assign accept   = InValid & InReady;
    assign OutValid = s2v_q;
    assign Result   = result_q;
    assign Flags    = flags_q;

    // ---------------- stage 1: decode ----------------
    logic [10:0]        exp_dbl;
    logic               frac_nz;
    logic signed [11:0] e_unb;
    logic               guard;
    logic               sticky_all;
    logic [2:0]         rm_norm;
    logic               rnd;
    s1_t                dec;

    assign exp_dbl    = Res[62:52];
    assign frac_nz    = |Res[51:0];
    assign e_unb      = $signed({1'b0, exp_dbl} - 12'(BIAS_DELTA));
    assign guard      = Res[28];
    assign sticky_all = (|Res[27:0]) | Sticky;
    assign rm_norm    = (Rm > RM_RMM) ? RM_RNE : Rm;

    div_round_single u_round (
        .sign_i   (Res[63]),
        .lsb_i    (Res[29]),
        .guard_i  (guard),
        .sticky_i (sticky_all),
        .rm_i     (rm_norm),
        .rnd_o    (rnd)
    );

    always_comb begin
        dec        = '0;
        dec.p      = P;
        dec.res    = Res;
        dec.sign   = Res[63];
        dec.exp    = e_unb[7:0];
        dec.man    = Res[51:29];
        dec.nx     = guard | sticky_all;
        dec.sticky = Sticky;
        dec.rnd    = rnd;
        dec.rm     = rm_norm;
        if (exp_dbl == 11'h7FF) begin
            dec.cls = frac_nz ? CLS_NAN : CLS_INF;
        end else if (exp_dbl == 11'h000) begin
            dec.cls = CLS_ZERO;
        end else if (e_unb >= 12'sd255) begin
            dec.cls = CLS_OVF;
        end else if (e_unb <= 12'sd0) begin
            dec.cls = CLS_UNF;
        end else begin
            dec.cls = CLS_NORMAL;
        end
    end

    // ---------------- stage 2: pack ----------------
    logic [30:0] sum;
    logic [31:0] ovf_res;
    logic [31:0] single;
    logic [2:0]  sflags;
    logic [63:0] pack_res;
    logic [2:0]  pack_flags;

    // A mantissa carry ripples into the exponent field naturally.
    assign sum     = {s1_q.exp, s1_q.man} + {30'd0, s1_q.rnd};
    assign ovf_res = {s1_q.sign, ovf_to_inf(s1_q.sign, s1_q.rm) ? 31'h7F80_0000 : 31'h7F7F_FFFF};

    always_comb begin
        single = 32'h0;
        sflags = 3'b000;
        case (s1_q.cls)
            CLS_NAN: single = SGL_QNAN;
            CLS_INF: single = {s1_q.sign, 8'hFF, 23'd0};
            CLS_ZERO: begin
                single = {s1_q.sign, 31'd0};
                sflags = {2'b00, s1_q.sticky};
            end
            CLS_OVF: begin
                single = ovf_res;
                sflags = 3'b101;
            end
            CLS_UNF: begin
                single = {s1_q.sign, 31'd0};
                sflags = 3'b011;
            end
            default: begin
                if (sum[30:23] == 8'hFF) begin
                    single = ovf_res;
                    sflags = 3'b101;
                end else begin
                    single = {s1_q.sign, sum};
                    sflags = {2'b00, s1_q.nx};
                end
            end
        endcase
        pack_res   = s1_q.p ? {NAN_BOX, single} : s1_q.res;
        pack_flags = s1_q.p ? sflags : 3'b000;
    end

    // ---------------- pipeline control ----------------
    always_comb begin
        s1v_d    = s1v_q;
        s1_d     = s1_q;
        s2v_d    = s2v_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (InReady) begin
            s1v_d = InValid;
        end
        if (accept) begin
            s1_d = dec;
        end
        if (advance1) begin
            s2v_d = s1v_q;
            if (s1v_q) begin
                result_d = pack_res;
                flags_d  = pack_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1v_q    <= 1'b0;
            s1_q     <= '0;
            s2v_q    <= 1'b0;
            result_q <= 64'd0;
            flags_q  <= 3'b000;
        end else begin
            s1v_q    <= s1v_d;
            s1_q     <= s1_d;
            s2v_q    <= s2v_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_convert_outputs_div.sv
// Scoreboard bench for convert_outputs_div: directed vectors, backpressure, reset-in-stall,
// then randomized traffic checked against an arithmetic reference model.
module tb_convert_outputs_div;

    logic        clk;
    logic        reset;
    logic        InValid;
    logic        InReady;
    logic [63:0] Res;
    logic        Sticky;
    logic        P;
    logic [2:0]  Rm;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] Result;
    logic [2:0]  Flags;

    int errors = 0;
    int checks = 0;
    logic [66:0] exp_q[$];
    bit rand_rdy = 0;

    convert_outputs_div dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Res      (Res),
        .Sticky   (Sticky),
        .P        (P),
        .Rm       (Rm),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .Flags    (Flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: truncate the 52-bit fraction to 23 bits and round by comparing the
    // discarded part with one half ulp, then apply the single-precision range rules.
    function automatic logic [66:0] model(input logic [63:0] r, input logic st,
                                          input logic p, input logic [2:0] rm);
        logic sg;
        int   e;
        longint unsigned frac, keep, rem, half;
        bit   up, inexact, to_inf;
        logic [66:0] ovfv;
        if (!p) return {r, 3'b000};
        sg   = r[63];
        e    = int'(r[62:52]);
        frac = 64'(r[51:0]);
        if (e == 2047)
            return (frac != 0) ? {32'hFFFFFFFF, 32'h7FC00000, 3'b000}
                               : {32'hFFFFFFFF, sg, 8'hFF, 23'h0, 3'b000};
        if (e == 0) return {32'hFFFFFFFF, sg, 31'h0, 2'b00, st};
        e      = e - 896;
        to_inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? sg : (rm == 3'd3) ? !sg : 1'b1;
        ovfv   = {32'hFFFFFFFF, sg, to_inf ? 31'h7F800000 : 31'h7F7FFFFF, 3'b101};
        if (e >= 255) return ovfv;
        if (e <= 0) return {32'hFFFFFFFF, sg, 31'h0, 3'b011};
        keep    = frac >> 29;
        rem     = frac & 64'h1FFFFFFF;
        half    = 64'h10000000;
        inexact = (rem != 0) || st;
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = sg && inexact;
            3'd3:    up = !sg && inexact;
            3'd4:    up = (rem >= half);
            default: up = (rem > half) || (rem == half && (st || keep[0]));
        endcase
        keep = keep + 64'(up);
        if (keep == 64'h800000) begin
            keep = 0;
            e    = e + 1;
        end
        if (e == 255) return ovfv;
        return {32'hFFFFFFFF, sg, 8'(e), 23'(keep), 2'b00, inexact};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [63:0] r, input logic st, input logic p,
                        input logic [2:0] rm, input logic [66:0] expv);
        bit acc = 0;
        int n = 0;
        Res = r; Sticky = st; P = p; Rm = rm; InValid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (InReady) begin
                acc = 1;
                exp_q.push_back(expv);
            end
            @(posedge clk);
            #1;
            n++;
        end
        InValid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got no InReady expected accept within 200 cycles");
        end
    endtask

    task automatic send_lat(input logic [63:0] r, input logic st, input logic p,
                            input logic [2:0] rm, input logic [66:0] expv);
        int n = 0;
        send(r, st, p, rm, expv);
        do begin
            @(negedge clk);
            n++;
        end while (!OutValid && n < 10);
        check("latency", 67'(n), 67'd2);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 67'(exp_q.size()), 67'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each output transfer and checks stability while stalled.
    initial begin
        bit          stalled = 0;
        logic [66:0] held = '0;
        logic [66:0] got;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 0;
            end else begin
                got = {Result, Flags};
                if (stalled && OutValid) check("stall_stable", got, held);
                if (OutValid && OutReady) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_output: got %h expected none", got);
                    end else begin
                        check("result", got, exp_q.pop_front());
                    end
                end
                stalled = OutValid && !OutReady;
                held    = got;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) OutReady = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400us");
        $fatal(1);
    end

    localparam logic [31:0] BOX = 32'hFFFFFFFF;

    initial begin
        logic [63:0] r;
        logic [10:0] ex;
        logic [51:0] fr;
        logic        st, p;
        logic [2:0]  rm;
        reset = 1'b1; InValid = 1'b0; Res = '0; Sticky = 1'b0; P = 1'b0; Rm = '0; OutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outvalid", 67'(OutValid), 67'd0);
        check("reset_inready", 67'(InReady), 67'd1);
        check("reset_result_flags", {Result, Flags}, 67'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors with the values they must produce.
        send_lat(64'h3FF0000000000000, 0, 1, 3'd0, {BOX, 32'h3F800000, 3'b000});
        send(64'h3FF0000010000000, 0, 1, 3'd0, {BOX, 32'h3F800000, 3'b001});
        send(64'h3FF0000010000000, 0, 1, 3'd3, {BOX, 32'h3F800001, 3'b001});
        send(64'h3FF0000010000000, 1, 1, 3'd0, {BOX, 32'h3F800001, 3'b001});
        send(64'h3FFFFFFFF0000000, 0, 1, 3'd0, {BOX, 32'h40000000, 3'b001});
        send(64'h47F0000000000000, 0, 1, 3'd0, {BOX, 32'h7F800000, 3'b101});
        send(64'h47F0000000000000, 0, 1, 3'd1, {BOX, 32'h7F7FFFFF, 3'b101});
        send(64'h7FF8000000000001, 0, 1, 3'd0, {BOX, 32'h7FC00000, 3'b000});
        send(64'h3800000000000000, 0, 1, 3'd0, {BOX, 32'h00000000, 3'b011});
        send(64'h400921FB54442D18, 0, 0, 3'd0, {64'h400921FB54442D18, 3'b000});
        drain();

        // Backpressure: two accepts fill the pipe, the third must wait for release.
        OutReady = 1'b0;
        send(64'h3FF0000000000000, 0, 1, 3'd0, {BOX, 32'h3F800000, 3'b000});
        send(64'h4000000000000000, 0, 1, 3'd0, {BOX, 32'h40000000, 3'b000});
        Res = 64'hC008000000000000; Sticky = 0; P = 1; Rm = 3'd0; InValid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_inready", 67'(InReady), 67'd0);
            @(posedge clk);
            #1;
        end
        OutReady = 1'b1;
        send(64'hC008000000000000, 0, 1, 3'd0, {BOX, 32'hC0400000, 3'b000});
        send(64'h3FF0000010000000, 0, 1, 3'd4, {BOX, 32'h3F800001, 3'b001});
        drain();

        // Asynchronous reset while both stages hold data.
        OutReady = 1'b0;
        send(64'h3FF0000000000000, 0, 1, 3'd0, {BOX, 32'h3F800000, 3'b000});
        send(64'h4000000000000000, 0, 1, 3'd0, {BOX, 32'h40000000, 3'b000});
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_outvalid", 67'(OutValid), 67'd0);
        check("async_rst_inready", 67'(InReady), 67'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        OutReady = 1'b1;
        send_lat(64'hBFF8000000000000, 0, 1, 3'd0, {BOX, 32'hBFC00000, 3'b000});
        drain();

        // Randomized traffic against the reference model.
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       ex = 11'h7FF;
                1:       ex = 11'h000;
                2:       ex = 11'($urandom_range(893, 898));
                3:       ex = 11'($urandom_range(1149, 1152));
                default: ex = 11'($urandom_range(897, 1150));
            endcase
            fr = {20'($urandom), $urandom};
            if ($urandom_range(0, 3) == 0) fr[28:0] = 29'h10000000;
            if ($urandom_range(0, 4) == 0) fr[51:29] = 23'h7FFFFF;
            if (ex == 11'h7FF && $urandom_range(0, 1) == 0) fr = '0;
            r  = {1'($urandom), ex, fr};
            st = 1'($urandom);
            p  = ($urandom_range(0, 7) != 0);
            rm = 3'($urandom_range(0, 7));
            send(r, st, p, rm, model(r, st, p, rm));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 0;
        OutReady = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
